clk_monitor: RTL

- Receive-side companion to the clock divider.
- Samples a slow, divided or external clock-like signal in the fast `clk` domain and synchronizes it.
- Emits single-cycle rise/fall strobes usable as clock enables.
- Measures the half-period in fast cycles and reports lock and stall status to the core and debug logic.

---
 rtl/clk_mon_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 39 +++
 rtl/clk_monitor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the slow-clock monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TRACK   = 2'd2
   } state_e;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int CNT_W_DEF       = 16;
   localparam int TIMEOUT_DEF     = 1000;
   localparam int LOCK_COUNT_DEF  = 4;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_bits(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered
// single-cycle rise/fall strobes.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Strobes are registered so they land SYNC_STAGES+1 cycles after the input moves.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= synced;
         rise_q <= synced & ~prev_q;
         fall_q <= ~synced & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// Slow-clock monitor: edge strobes, half-period measurement, lock and stall.
// Define CLK_MON_DUTY_EN to add high_time_o / low_time_o duty outputs.
module clk_monitor
   import clk_mon_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_i,
   output logic             rise_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] half_period_o,
   output logic             period_valid_o,
   output logic             locked_o,
   output logic             stalled_o
`ifdef CLK_MON_DUTY_EN
   ,
   output logic [CNT_W-1:0] high_time_o,
   output logic [CNT_W-1:0] low_time_o
`endif
);

   localparam int               MW      = cnt_bits(LOCK_COUNT);
   localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hp_q, hp_d;
   logic [MW-1:0]    match_q, match_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             stalled_q, stalled_d;
   logic [CNT_W-1:0] meas;
   logic             rise, fall, edge_seen;
`ifdef CLK_MON_DUTY_EN
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
`endif

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (slow_i),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   assign edge_seen = rise | fall;
   // A saturated counter still reports the maximum rather than wrapping.
   assign meas      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hp_d      = hp_q;
      match_d   = match_q;
      valid_d   = valid_q;
      locked_d  = locked_q;
      stalled_d = stalled_q;
`ifdef CLK_MON_DUTY_EN
      high_d    = high_q;
      low_d     = low_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (edge_seen) begin
               state_d   = ST_MEASURE;
               stalled_d = 1'b0;
            end
         end
         ST_MEASURE, ST_TRACK: begin
            if (edge_seen) begin
               cnt_d = '0;
               hp_d  = meas;
`ifdef CLK_MON_DUTY_EN
               if (fall) high_d = meas;
               if (rise) low_d  = meas;
`endif
               if (state_q == ST_MEASURE) begin
                  valid_d = 1'b1;
                  match_d = '0;
                  state_d = ST_TRACK;
               end else if (meas == hp_q) begin
                  match_d  = (match_q == LOCK_M) ? LOCK_M : match_q + 1'b1;
                  locked_d = (match_d == LOCK_M);
               end else begin
                  match_d  = '0;
                  locked_d = 1'b0;
               end
            end else if (cnt_q == TO_LAST) begin
               // Stall: drop status but keep the last measurement visible.
               stalled_d = 1'b1;
               locked_d  = 1'b0;
               valid_d   = 1'b0;
               match_d   = '0;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hp_q      <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         stalled_q <= 1'b0;
`ifdef CLK_MON_DUTY_EN
         high_q    <= '0;
         low_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         stalled_q <= stalled_d;
`ifdef CLK_MON_DUTY_EN
         high_q    <= high_d;
         low_q     <= low_d;
`endif
      end
   end

   assign rise_o         = rise;
   assign fall_o         = fall;
   assign half_period_o  = hp_q;
   assign period_valid_o = valid_q;
   assign locked_o       = locked_q;
   assign stalled_o      = stalled_q;
`ifdef CLK_MON_DUTY_EN
   assign high_time_o    = high_q;
   assign low_time_o     = low_q;
`endif

endmodule
